l1ci_axi_rd_master: RTL and testbench

// Downstream stage of the instruction L1 cache, on the CPU-wrapper side of I_req/I_addr.

---
 rtl/l1ci_axi_rd_master_pkg.sv | 19 +
 rtl/l1ci_axi_rd_master_if.sv | 40 ++++
 rtl/l1ci_axi_rd_master.sv | 103 ++++++++++
 tb/tb_l1ci_axi_rd_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l1ci_axi_rd_master_pkg.sv
// Shared AXI read constants and the refill FSM state type
// for the instruction-cache read master.
package l1ci_axi_rd_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DONE
  } rd_state_e;

endpackage

// File: rtl/l1ci_axi_rd_master_if.sv
// AXI4 read address and read data channels
// between the refill master and the memory slave.
interface l1ci_axi_rd_master_if #(
  parameter int ID_W = 4
);

  logic [ID_W-1:0] ARID_M;
  logic [31:0]     ARADDR_M;
  logic [3:0]      ARLEN_M;
  logic [2:0]      ARSIZE_M;
  logic [1:0]      ARBURST_M;
  logic            ARVALID_M;
  logic            ARREADY_M;

  logic [ID_W-1:0] RID_M;
  logic [31:0]     RDATA_M;
  logic [1:0]      RRESP_M;
  logic            RLAST_M;
  logic            RVALID_M;
  logic            RREADY_M;

  modport master (
    output ARID_M, ARADDR_M, ARLEN_M,
    output ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  RID_M, RDATA_M, RRESP_M,
    input  RLAST_M, RVALID_M,
    output RREADY_M
  );

  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M,
    input  ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output RID_M, RDATA_M, RRESP_M,
    output RLAST_M, RVALID_M,
    input  RREADY_M
  );

endinterface

// File: rtl/l1ci_axi_rd_master.sv
// Instruction-cache line refill: one AXI4 INCR read burst
// per request, words streamed to the cache as they arrive.
module l1ci_axi_rd_master
  import l1ci_axi_rd_master_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int MST_ID    = 0,
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_req,
  input  logic [31:0] I_addr,
  input  logic        I_write,
  input  logic [2:0]  I_type,
  output logic [31:0] I_out,
  output logic        I_wait,
  output logic        err_o,
  l1ci_axi_rd_master_if.master axi
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam int OFF_W = CNT_W + 2;
  localparam logic [ID_W-1:0]  ID_C   = ID_W'(MST_ID);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BURST_LEN - 1);

  rd_state_e        state_q;
  logic             arvalid_q;
  logic             rready_q;
  logic [31:0]      araddr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic beat;
  logic last_beat;
  logic unused_ok;

  assign beat      = (state_q == R) && axi.RVALID_M;
  assign last_beat = (cnt_q == LAST_C);

  assign axi.ARID_M    = ID_C;
  assign axi.ARADDR_M  = araddr_q;
  assign axi.ARLEN_M   = 4'(BURST_LEN - 1);
  assign axi.ARSIZE_M  = AXI_SIZE_4B;
  assign axi.ARBURST_M = AXI_BURST_INCR;
  assign axi.ARVALID_M = arvalid_q;
  assign axi.RREADY_M  = rready_q;

  // No R-side buffer: the beat goes straight to the cache.
  assign I_wait = ~beat;
  assign I_out  = beat ? axi.RDATA_M : 32'h0;
  assign err_o  = err_q;

  assign unused_ok = ^{I_type, I_addr[OFF_W-1:0], axi.RID_M};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= 32'h0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (I_req && I_write) begin
            err_q <= 1'b1;
          end else if (I_req) begin
            state_q   <= AR;
            arvalid_q <= 1'b1;
            araddr_q  <= {I_addr[31:OFF_W], {OFF_W{1'b0}}};
            cnt_q     <= '0;
          end
        end
        AR: begin
          if (axi.ARREADY_M) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= R;
          end
        end
        R: begin
          if (axi.RVALID_M) begin
            cnt_q <= cnt_q + 1'b1;
            if (axi.RRESP_M != AXI_RESP_OKAY)
              err_q <= 1'b1;
            // RLAST must coincide with the final counted beat.
            if (axi.RLAST_M != last_beat)
              err_q <= 1'b1;
            if (axi.RLAST_M) begin
              rready_q <= 1'b0;
              state_q  <= DONE;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1ci_axi_rd_master.sv
// Bench for the refill read master: table rows, hand sequences
// and random bursts against a burst-level reference model.
module tb_l1ci_axi_rd_master;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_req;
  logic [31:0] I_addr;
  logic        I_write;
  logic [2:0]  I_type;
  logic [31:0] I_out;
  logic        I_wait;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  l1ci_axi_rd_master_if #(.ID_W(4)) s ();

  l1ci_axi_rd_master #(
    .ID_W(4), .MST_ID(0), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst),
    .I_req(I_req), .I_addr(I_addr),
    .I_write(I_write), .I_type(I_type),
    .I_out(I_out), .I_wait(I_wait),
    .err_o(err_o), .axi(s)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  typedef struct {
    logic        rst_first;
    logic [31:0] addr;
    int          ard;
    logic [15:0] vpat;
    int          errb;
    int          lastb;
    logic [31:0] exp_ad;
    logic        exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    I_req = 1'b0;
    I_write = 1'b0;
    s.ARREADY_M = 1'b0;
    s.RVALID_M = 1'b0;
    s.RLAST_M = 1'b0;
    s.RRESP_M = 2'b00;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_arvalid", s.ARVALID_M, 0);
    chk("rst_rready", s.RREADY_M, 0);
    chk("rst_araddr", s.ARADDR_M, 0);
    chk("rst_iwait", I_wait, 1);
    chk("rst_iout", I_out, 0);
    chk("rst_err", err_o, 0);
  endtask

  // One refill: AR accepted after ard cycles, beats gated by
  // vpat (LSB first, then always valid), RLAST on beat lastb.
  task automatic run_burst(input logic [31:0] addr,
                           input int ard,
                           input logic [15:0] vpat,
                           input int errb,
                           input int lastb,
                           input logic [31:0] exp_ad);
    int hs = 0;
    int k = 0;
    int cyc = 0;
    logic vb;
    I_req = 1'b1;
    I_addr = addr;
    I_write = 1'b0;
    I_type = 3'($urandom);
    #1;
    chk("idle_iwait", I_wait, 1);
    tick;
    for (int d = 0; d <= ard; d++) begin
      s.ARREADY_M = (d == ard);
      #1;
      chk("ar_valid", s.ARVALID_M, 1);
      chk("ar_addr", s.ARADDR_M, exp_ad);
      chk("ar_iwait", I_wait, 1);
      if (s.ARVALID_M && s.ARREADY_M) hs++;
      tick;
    end
    s.ARREADY_M = 1'b0;
    chk("ar_handshakes", hs, 1);
    while (k <= lastb && cyc < 64) begin
      vb = (cyc < 16) ? vpat[cyc] : 1'b1;
      s.RVALID_M = vb;
      s.RDATA_M = $urandom;
      s.RRESP_M = (vb && k == errb) ? 2'b10 : 2'b00;
      s.RLAST_M = vb && (k == lastb);
      #1;
      chk("r_rready", s.RREADY_M, 1);
      chk("r_arvalid", s.ARVALID_M, 0);
      chk("r_iwait", I_wait, {31'b0, !vb});
      chk("r_iout", I_out, vb ? s.RDATA_M : 32'h0);
      if (vb) k++;
      cyc++;
      tick;
    end
    if (cyc >= 64) chk("r_timeout", cyc, 0);
    s.RVALID_M = 1'b0;
    s.RLAST_M = 1'b0;
    s.RRESP_M = 2'b00;
    #1;
    chk("done_iwait", I_wait, 1);
    chk("done_rready", s.RREADY_M, 0);
    chk("done_arvalid", s.ARVALID_M, 0);
    tick;
    I_req = 1'b0;
    #1;
    chk("stale_arvalid", s.ARVALID_M, 0);
    chk("stale_iwait", I_wait, 1);
    tick;
  endtask

  initial begin
    logic        err_m;
    logic [31:0] ra;
    int          rd, eb, lb;
    logic [15:0] vp;

    rst = 1'b1;
    I_req = 1'b0;
    I_addr = 32'h0;
    I_write = 1'b0;
    I_type = 3'b0;
    s.ARREADY_M = 1'b0;
    s.RID_M = 4'h0;
    s.RDATA_M = 32'h0;
    s.RRESP_M = 2'b00;
    s.RLAST_M = 1'b0;
    s.RVALID_M = 1'b0;

    tbl[0] = '{1'b1, 32'h0000_1234, 0, 16'hFFFF, -1, 3, 32'h0000_1230, 1'b0};
    tbl[1] = '{1'b0, 32'hABCD_EF08, 5, 16'hFFFF, -1, 3, 32'hABCD_EF00, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0040, 1, 16'h0059, -1, 3, 32'h0000_0040, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0100, 0, 16'hFFFF,  2, 3, 32'h0000_0100, 1'b1};
    tbl[4] = '{1'b0, 32'h0000_0204, 0, 16'h00F0, -1, 3, 32'h0000_0200, 1'b1};
    tbl[5] = '{1'b1, 32'h0000_0300, 0, 16'hFFFF, -1, 2, 32'h0000_0300, 1'b1};
    tbl[6] = '{1'b0, 32'h0000_031C, 2, 16'hFFFF, -1, 3, 32'h0000_0310, 1'b1};
    tbl[7] = '{1'b1, 32'hFFFF_FFFC, 2, 16'h5555, -1, 3, 32'hFFFF_FFF0, 1'b0};
    tbl[8] = '{1'b0, 32'h0000_5000, 0, 16'hFFFF, -1, 4, 32'h0000_5000, 1'b1};

    reset_dut;
    chk("arid", 32'(s.ARID_M), 0);
    chk("arlen", 32'(s.ARLEN_M), BL - 1);
    chk("arsize", 32'(s.ARSIZE_M), 2);
    chk("arburst", 32'(s.ARBURST_M), 1);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst_first) reset_dut;
      run_burst(tbl[i].addr, tbl[i].ard, tbl[i].vpat,
                tbl[i].errb, tbl[i].lastb, tbl[i].exp_ad);
      #1;
      chk($sformatf("tbl%0d_err", i), err_o, tbl[i].exp_err);
    end

    // Write request: error flagged, no AR issued.
    reset_dut;
    I_req = 1'b1;
    I_write = 1'b1;
    #1;
    chk("wr_iwait", I_wait, 1);
    tick;
    I_req = 1'b0;
    I_write = 1'b0;
    #1;
    chk("wr_err", err_o, 1);
    chk("wr_arvalid", s.ARVALID_M, 0);
    chk("wr_iwait2", I_wait, 1);
    tick;

    // Reset in the middle of a burst, then a fresh refill.
    reset_dut;
    I_req = 1'b1;
    I_addr = 32'h0000_0080;
    tick;
    s.ARREADY_M = 1'b1;
    tick;
    s.ARREADY_M = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s.RVALID_M = 1'b1;
      s.RDATA_M = 32'hC0DE_0000 + 32'(b);
      #1;
      chk("mid_iout", I_out, 32'hC0DE_0000 + 32'(b));
      tick;
    end
    s.RVALID_M = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    I_req = 1'b0;
    #1;
    chk("mid_rready", s.RREADY_M, 0);
    chk("mid_iwait", I_wait, 1);
    chk("mid_arvalid", s.ARVALID_M, 0);
    run_burst(32'h40, 0, 16'hFFFF, -1, 3, 32'h40);

    // Random bursts against the burst-level error model.
    reset_dut;
    err_m = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        reset_dut;
        err_m = 1'b0;
      end
      ra = $urandom;
      rd = $urandom_range(0, 3);
      vp = 16'($urandom);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : BL - 1;
      if (eb >= 0 && eb <= lb) err_m = 1'b1;
      if (lb != BL - 1) err_m = 1'b1;
      run_burst(ra, rd, vp, eb, lb, ra & ~32'(BL * 4 - 1));
      #1;
      chk($sformatf("rnd%0d_err", i), err_o, err_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
